mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One operand bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
//   state | meaning
//   IDLE  | waiting for Start
//   RUN   | WIDTH iterations of shift-add or restoring divide
//   FIX   | apply signs, load HI/LO
//   DONE  | one-cycle Done pulse; accepts a new Start
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 sign_a_q, sign_a_d;
  logic [WIDTH-1:0]     a_orig_q, a_orig_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      a_orig_q <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      a_orig_q <= a_orig_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    a_orig_d = a_orig_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // MDOperation[0] set means unsigned; only signed ops take magnitudes.
    signed_op = ~MDOperation[0];
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;

    // Multiply: acc = {partial hi, remaining multiplier}, shifted right each step.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_q};

    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          is_div_d = MDOperation[1];
          neg_d    = a_neg ^ b_neg;
          sign_a_d = a_neg;
          a_orig_d = A;
          b_mag_d  = b_mag;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          cnt_d    = '0;
          dbz_d    = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          if (b_mag_q == '0) begin
            hi_d  = a_orig_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_q ? -quo : quo;
            hi_d = sign_a_q ? -rem : rem;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy      = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done      = (state_q == S_DONE);
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOperation;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOperation(MDOperation),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    logic [64:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      2'b00: begin sp = sa * sb; res = {1'b0, sp[63:0]}; end
      2'b01: begin up = ua * ub; res = {1'b0, up[63:0]}; end
      2'b10: begin
        if (b == 0) res = {1'b1, a, 32'hFFFF_FFFF};
        else begin sq = sa / sb; sr = sa % sb; res = {1'b0, sr[31:0], sq[31:0]}; end
      end
      default: begin
        if (b == 0) res = {1'b1, a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua % ub; res = {1'b0, ur[31:0], uq[31:0]}; end
      end
    endcase
    return res;
  endfunction

  // Caller is between edges; request is sampled at the next rising edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOperation = op; A = a; B = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until Done is seen.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 999;
    busy_n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (Busy) busy_n++;
      if (Done) begin lat = c; break; end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    start_op(op, a, b);
    wait_done(lat, busy_n);
  endtask

  initial begin
    int lat, busy_n, done_n;
    logic [64:0] exp;
    logic [31:0] hold_hi, hold_lo;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[5] = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{2'b01, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
    vecs[7] = '{2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};

    reset = 1'b1; Start = 1'b0; MDOperation = 2'b00; A = '0; B = '0;
    #12;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_dbz",  64'(DivByZero), 64'd0);
    chk("reset_hi",   64'(HI), 64'd0);
    chk("reset_lo",   64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd33);
      chk($sformatf("vec%0d_hi", i), 64'(HI), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(LO), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dbz", i), 64'(DivByZero), 64'(vecs[i].dbz));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(Done), 64'd0);
    end

    // Back-to-back: new Start issued in the DONE cycle.
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, busy_n);
    chk("b2b_first_lo", 64'(LO), 64'hFFFF_FFF1);
    start_op(2'b11, 32'd100, 32'd7);
    chk("b2b_busy_after_start", 64'(Busy), 64'd1);
    wait_done(lat, busy_n);
    chk("b2b_latency", 64'(lat), 64'd34);
    chk("b2b_lo", 64'(LO), 64'd14);
    chk("b2b_hi", 64'(HI), 64'd2);

    // DivByZero clears at the accepting edge of the next request.
    run_op(2'b11, 32'd100, 32'd0, lat, busy_n);
    chk("dbz_set", 64'(DivByZero), 64'd1);
    @(negedge clk);
    chk("dbz_held_idle", 64'(DivByZero), 64'd1);
    start_op(2'b01, 32'd2, 32'd3);
    chk("dbz_cleared_at_start", 64'(DivByZero), 64'd0);
    chk("hi_held_during_run", 64'(HI), 64'd100);
    wait_done(lat, busy_n);
    chk("after_dbz_lo", 64'(LO), 64'd6);
    chk("after_dbz_hi", 64'(HI), 64'd0);

    // Start pulses while busy must be ignored.
    @(negedge clk);
    start_op(2'b01, 32'd7, 32'd9);
    done_n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (Done) begin
        done_n++;
        chk("ignore_lo", 64'(LO), 64'd63);
        chk("ignore_hi", 64'(HI), 64'd0);
        chk("ignore_latency", 64'(c), 64'd34);
      end
      if (c == 5 || c == 20) begin
        Start = 1'b1; MDOperation = 2'b10; A = 32'd1000; B = 32'd3;
      end else begin
        Start = 1'b0;
      end
    end
    chk("ignore_done_count", 64'(done_n), 64'd1);
    chk("hold_lo_idle", 64'(LO), 64'd63);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    start_op(2'b11, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(Busy), 64'd0);
    chk("async_rst_done", 64'(Done), 64'd0);
    chk("async_rst_hi",   64'(HI), 64'd0);
    chk("async_rst_lo",   64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd4, 32'd4, lat, busy_n);
    chk("post_rst_latency", 64'(lat), 64'd34);
    chk("post_rst_lo", 64'(LO), 64'd16);
    chk("post_rst_hi", 64'(HI), 64'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, lat, busy_n);
      chk($sformatf("rnd%0d_op%0d_latency", i, rop), 64'(lat), 64'd34);
      chk($sformatf("rnd%0d_op%0d_a%h_b%h_hi", i, rop, ra, rb), 64'(HI), 64'(exp[63:32]));
      chk($sformatf("rnd%0d_op%0d_a%h_b%h_lo", i, rop, ra, rb), 64'(LO), 64'(exp[31:0]));
      chk($sformatf("rnd%0d_op%0d_dbz", i, rop), 64'(DivByZero), 64'(exp[64]));
    end

    // HI/LO hold while idle.
    hold_hi = HI;
    hold_lo = LO;
    exp = model(rop, ra, rb);
    repeat (5) @(negedge clk);
    chk("idle_hold_hi", 64'(HI), 64'(exp[63:32]));
    chk("idle_hold_lo", 64'(LO), 64'(exp[31:0]));
    chk("idle_hold_hi_snapshot", 64'(HI), 64'(hold_hi));
    chk("idle_hold_lo_snapshot", 64'(LO), 64'(hold_lo));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
